// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the 5-stage RISC-V pipeline.
package rv_pipe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch-stage FSM encoding
    typedef logic [1:0] if_state_t;

    localparam if_state_t IF_FETCH = 2'd0;
    localparam if_state_t IF_WAIT  = 2'd1;
    localparam if_state_t IF_HOLD  = 2'd2;
    localparam if_state_t IF_DROP  = 2'd3;

    // Next-PC source select
    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_INC      = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with redirect / increment / hold next-PC mux.
module if_pc_reg
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  pc_sel_e         sel_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Increment wraps naturally modulo 2^32
    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_SEL_INC:      pc_d = pc_q + PC_INC;
            PC_SEL_REDIRECT: pc_d = target_i;
            default:         pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem port, hold register.
// Optional IF_PERF_EN adds FetchCount / SquashCount performance counters.
module if_fetch_unit
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemReady,
    input  logic            ImemRValid,
    input  logic [XLEN-1:0] ImemRData,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            FetchValidF
`ifdef IF_PERF_EN
    ,
    output logic [31:0]     FetchCount,
    output logic [31:0]     SquashCount
`endif
);

    if_state_t       state_q;
    if_state_t       state_d;
    logic [XLEN-1:0] instr_q;
    logic            valid_q;
    logic            valid_d;
    logic            capture;
    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .sel_i    (pc_sel),
        .target_i (PCTargetE),
        .pc_o     (pc)
    );

    // Next state; a redirect outranks stall and any same-cycle response
    always_comb begin
        state_d = state_q;
        pc_sel  = PC_SEL_HOLD;
        capture = 1'b0;
        ImemReq = 1'b0;
        case (state_q)
            IF_FETCH: begin
                if (PCSrcE) begin
                    pc_sel = PC_SEL_REDIRECT;
                end else begin
                    ImemReq = 1'b1;
                    if (ImemReady) begin
                        state_d = IF_WAIT;
                    end
                end
            end
            IF_WAIT: begin
                if (PCSrcE) begin
                    pc_sel  = PC_SEL_REDIRECT;
                    state_d = ImemRValid ? IF_FETCH : IF_DROP;
                end else if (ImemRValid) begin
                    capture = 1'b1;
                    state_d = IF_HOLD;
                end
            end
            IF_HOLD: begin
                if (PCSrcE) begin
                    pc_sel  = PC_SEL_REDIRECT;
                    state_d = IF_FETCH;
                end else if (!StallF) begin
                    pc_sel  = PC_SEL_INC;
                    state_d = IF_FETCH;
                end
            end
            IF_DROP: begin
                if (PCSrcE) begin
                    pc_sel = PC_SEL_REDIRECT;
                end
                if (ImemRValid) begin
                    state_d = IF_FETCH;
                end
            end
            default: begin
                state_d = IF_FETCH;
            end
        endcase
        valid_d = (state_d == IF_HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IF_FETCH;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Hold register keeps the last captured word even after it is squashed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
        end else if (capture) begin
            instr_q <= ImemRData;
        end
    end

    assign ImemAddr    = pc;
    assign PCF         = pc;
    assign PCPlus4F    = pc + PC_INC;
    assign InstrF      = instr_q;
    assign FetchValidF = valid_q;

`ifdef IF_PERF_EN
    logic        consume_c;
    logic        squash_c;
    logic [31:0] fetch_cnt_q;
    logic [31:0] squash_cnt_q;

    assign consume_c = (state_q == IF_HOLD) && !PCSrcE && !StallF;
    assign squash_c  = PCSrcE && ((state_q == IF_HOLD) || (state_q == IF_WAIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (consume_c) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (squash_c) begin
                squash_cnt_q <= squash_cnt_q + 32'd1;
            end
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign SquashCount = squash_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a transaction-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRValid;
    logic [31:0] ImemRData;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        FetchValidF;

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 1;
    bit done     = 1'b0;

    if_fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemReady   (ImemReady),
        .ImemRValid  (ImemRValid),
        .ImemRData   (ImemRData),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .FetchValidF (FetchValidF)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural PC, held-instruction flag, outstanding request
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_out;
    bit          m_live;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc    <= RST_PC;
            m_valid <= 1'b0;
            m_out   <= 1'b0;
            m_live  <= 1'b0;
        end else if (PCSrcE) begin
            m_pc    <= PCTargetE;
            m_valid <= 1'b0;
            if (m_out && ImemRValid) m_out <= 1'b0;
            else if (m_out)          m_live <= 1'b0;
        end else if (m_valid) begin
            if (!StallF) begin
                m_pc    <= m_pc + 32'd4;
                m_valid <= 1'b0;
            end
        end else if (!m_out) begin
            if (ImemReady) begin
                m_out  <= 1'b1;
                m_live <= 1'b1;
            end
        end else if (ImemRValid) begin
            m_out   <= 1'b0;
            m_valid <= m_live;
        end
    end

    // Compare process: every cycle out of reset
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && !done) begin
                chk("pcf",       PCF,      m_pc);
                chk("imem_addr", ImemAddr, m_pc);
                chk("pcplus4",   PCPlus4F, m_pc + 32'd4);
                chk("valid",     32'(FetchValidF), 32'(m_valid));
                chk("imem_req",  32'(ImemReq), 32'(!m_out && !m_valid && !PCSrcE));
                if (m_valid) chk("instr", InstrF, mem_word(m_pc));
            end
        end
    end

    // Memory responder: fixed latency lat after acceptance
    bit          acc_s;
    bit          rv_s;
    bit          pending;
    int          cnt;
    logic [31:0] addr_s;
    logic [31:0] pend_addr;

    initial begin
        ImemRValid = 1'b0;
        ImemRData  = 32'h0;
        pending    = 1'b0;
        cnt        = 0;
        pend_addr  = 32'h0;
        forever begin
            @(negedge clk);
            acc_s  = (reset_n === 1'b1) && ImemReq && ImemReady;
            addr_s = ImemAddr;
            rv_s   = ImemRValid;
            @(posedge clk);
            #1;
            ImemRValid = 1'b0;
            if (reset_n !== 1'b1) begin
                pending = 1'b0;
            end else begin
                if (rv_s) pending = 1'b0;
                if (acc_s) begin
                    pending   = 1'b1;
                    cnt       = lat;
                    pend_addr = addr_s;
                end
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        ImemRValid = 1'b1;
                        ImemRData  = mem_word(pend_addr);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        StallF    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
        ImemReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pcf",   PCF, 32'h0000_0100);
        chk("rst_valid", 32'(FetchValidF), 32'd0);
        chk("rst_instr", InstrF, 32'h0);

        // Release reset: first request in the first cycle
        tick(); reset_n = 1'b1;
        @(negedge clk);
        chk("first_req",  32'(ImemReq), 32'd1);
        chk("first_addr", ImemAddr, 32'h0000_0100);
        tick(); tick();
        @(negedge clk);
        chk("first_valid", 32'(FetchValidF), 32'd1);
        chk("first_pcf",   PCF, 32'h0000_0100);
        chk("first_instr", InstrF, 32'hA5A5_0100);
        tick();
        @(negedge clk);
        chk("seq_addr1", ImemAddr, 32'h0000_0104);
        tick(); tick();
        @(negedge clk);
        chk("seq_pcf1",   PCF, 32'h0000_0104);
        chk("seq_plus4",  PCPlus4F, 32'h0000_0108);
        chk("seq_instr1", InstrF, 32'hA5A5_0104);
        tick(); tick(); tick();

        // Stall four cycles in HOLD
        StallF = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_req",   32'(ImemReq), 32'd0);
            chk("stall_pcf",   PCF, 32'h0000_0108);
            chk("stall_instr", InstrF, 32'hA5A5_0108);
            tick();
        end
        StallF = 1'b0;
        lat    = 3;
        tick();
        @(negedge clk);
        chk("post_stall_req",  32'(ImemReq), 32'd1);
        chk("post_stall_addr", ImemAddr, 32'h0000_010C);

        // Redirect while waiting; the late response must be dropped
        tick(); PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
        tick(); PCSrcE = 1'b0; lat = 1;
        @(negedge clk);
        chk("drop_valid0", 32'(FetchValidF), 32'd0);
        tick();
        @(negedge clk);
        chk("drop_valid1", 32'(FetchValidF), 32'd0);
        tick();
        @(negedge clk);
        chk("redir_req",  32'(ImemReq), 32'd1);
        chk("redir_addr", ImemAddr, 32'h0000_0200);
        tick(); tick();
        @(negedge clk);
        chk("redir_instr", InstrF, 32'hA5A5_0200);

        // Redirect coinciding with the response in WAIT
        tick(); tick(); PCSrcE = 1'b1; PCTargetE = 32'h0000_0300;
        tick(); PCSrcE = 1'b0;
        @(negedge clk);
        chk("same_cyc_valid", 32'(FetchValidF), 32'd0);
        chk("same_cyc_addr",  ImemAddr, 32'h0000_0300);
        tick(); tick();

        // Redirect with stall in HOLD
        StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0400;
        tick(); StallF = 1'b0; PCSrcE = 1'b0;
        @(negedge clk);
        chk("hold_redir_addr", ImemAddr, 32'h0000_0400);
        chk("hold_redir_req",  32'(ImemReq), 32'd1);
        tick(); tick();
        @(negedge clk);
        chk("hold_redir_instr", InstrF, 32'hA5A5_0400);

        // Memory not ready for three cycles
        tick(); ImemReady = 1'b0; lat = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nrdy_req",  32'(ImemReq), 32'd1);
            chk("nrdy_addr", ImemAddr, 32'h0000_0404);
            tick();
        end
        ImemReady = 1'b1;
        tick();
        @(negedge clk);
        chk("wait_req", 32'(ImemReq), 32'd0);

        // Asynchronous reset in the middle of WAIT
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_pcf",   PCF, 32'h0000_0100);
        chk("async_valid", 32'(FetchValidF), 32'd0);
        chk("async_instr", InstrF, 32'h0);
        lat = 1;
        tick(); reset_n = 1'b1;
        @(negedge clk);
        chk("rerun_addr", ImemAddr, 32'h0000_0100);
        tick(); tick();
        @(negedge clk);
        chk("rerun_instr", InstrF, 32'hA5A5_0100);
        tick();

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
